// File: rtl/multi_channel_fifo.sv
// Bank of NUM_CH independent circular FIFOs sharing one write port and one read port.
// Latency: a write is visible on data_out the cycle after it is accepted; data_out is combinational.
// Backpressure: writes to a full channel are dropped (overflow), reads of an empty channel ignored (underflow).
module multi_channel_fifo #(
   parameter  int WIDTH     = 32,
   parameter  int DEPTH     = 4,
   parameter  int NUM_CH    = 2,
   parameter  int AF_THRESH = DEPTH - 1,
   localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNTW      = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   we,
   input  logic [CHW-1:0]         wr_ch,
   input  logic                   re,
   input  logic [CHW-1:0]         rd_ch,
   input  logic                   clear_err,
   output logic [WIDTH-1:0]       data_out,
   output logic [NUM_CH-1:0]      full,
   output logic [NUM_CH-1:0]      empty,
   output logic [NUM_CH-1:0]      almost_full,
   output logic [NUM_CH*CNTW-1:0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] AF_CNT   = CNTW'(AF_THRESH);

   logic [WIDTH-1:0] mem   [NUM_CH][DEPTH];
   logic [PW-1:0]    wrptr [NUM_CH];
   logic [PW-1:0]    rdptr [NUM_CH];
   logic [CNTW-1:0]  cnt   [NUM_CH];

   logic [NUM_CH-1:0] wr_acc;
   logic [NUM_CH-1:0] rd_acc;
   logic              overflow_set;
   logic              underflow_set;

   // Per-channel status flags and flattened occupancy
   always_comb begin
      full        = '0;
      empty       = '0;
      almost_full = '0;
      count       = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]                 = (cnt[c] == FULL_CNT);
         empty[c]                = (cnt[c] == '0);
         almost_full[c]          = (cnt[c] >= AF_CNT);
         count[c*CNTW +: CNTW]   = cnt[c];
      end
   end

   // Acceptance decode; an out-of-range channel never matches, so its request is rejected
   always_comb begin
      wr_acc = '0;
      rd_acc = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rd_acc[c] = re && (rd_ch == CHW'(c)) && !empty[c];
         // a full queue still takes a write when the same queue is popped this cycle
         wr_acc[c] = we && (wr_ch == CHW'(c)) && (!full[c] || (re && (rd_ch == CHW'(c))));
      end
      overflow_set  = we && (wr_acc == '0);
      underflow_set = re && (rd_acc == '0);
   end

   // Head of the selected channel, zero when that channel is empty or does not exist
   always_comb begin
      data_out = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if ((rd_ch == CHW'(c)) && !empty[c]) begin
            data_out = mem[c][rdptr[c]];
         end
      end
   end

   // Storage write; contents are don't-care after reset, so no reset here
   always_ff @(posedge clock) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_acc[c]) begin
            mem[c][wrptr[c]] <= data_in;
         end
      end
   end

   // Pointer and occupancy update with explicit wrap at DEPTH-1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wrptr[c] <= '0;
            rdptr[c] <= '0;
            cnt[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c]) begin
               wrptr[c] <= (wrptr[c] == LAST_PTR) ? '0 : wrptr[c] + 1'b1;
            end
            if (rd_acc[c]) begin
               rdptr[c] <= (rdptr[c] == LAST_PTR) ? '0 : rdptr[c] + 1'b1;
            end
            case ({wr_acc[c], rd_acc[c]})
               2'b10:   cnt[c] <= cnt[c] + 1'b1;
               2'b01:   cnt[c] <= cnt[c] - 1'b1;
               default: cnt[c] <= cnt[c];
            endcase
         end
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow_set  || (overflow  && !clear_err);
         underflow <= underflow_set || (underflow && !clear_err);
      end
   end

endmodule

// File: tb/tb_multi_channel_fifo.sv
module tb_multi_channel_fifo;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 3;
   localparam int NUM_CH = 2;
   localparam int AF     = DEPTH - 1;
   localparam int CHW    = 1;
   localparam int CNTW   = 2;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   logic [WIDTH-1:0]       data_in = '0;
   logic                   we = 1'b0;
   logic [CHW-1:0]         wr_ch = '0;
   logic                   re = 1'b0;
   logic [CHW-1:0]         rd_ch = '0;
   logic                   clear_err = 1'b0;
   logic [WIDTH-1:0]       data_out;
   logic [NUM_CH-1:0]      full;
   logic [NUM_CH-1:0]      empty;
   logic [NUM_CH-1:0]      almost_full;
   logic [NUM_CH*CNTW-1:0] count;
   logic                   overflow;
   logic                   underflow;

   int checks = 0;
   int errors = 0;

   multi_channel_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AF_THRESH(AF)
   ) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .we(we), .wr_ch(wr_ch),
      .re(re), .rd_ch(rd_ch), .clear_err(clear_err), .data_out(data_out),
      .full(full), .empty(empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one queue per channel ----------------
   logic [WIDTH-1:0] mq [NUM_CH][$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   function automatic bit m_racc();
      return re && (int'(rd_ch) < NUM_CH) && (mq[rd_ch].size() > 0);
   endfunction

   function automatic bit m_wacc();
      return we && (int'(wr_ch) < NUM_CH) &&
             ((mq[wr_ch].size() < DEPTH) || (re && rd_ch == wr_ch));
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) mq[c].delete();
         m_ovf <= 1'b0;
         m_unf <= 1'b0;
      end else begin
         m_ovf <= (we && !m_wacc()) || (m_ovf && !clear_err);
         m_unf <= (re && !m_racc()) || (m_unf && !clear_err);
         if (m_racc()) begin
            if (m_wacc()) begin
               void'(mq[rd_ch].pop_front());
               mq[wr_ch].push_back(data_in);
            end else begin
               void'(mq[rd_ch].pop_front());
            end
         end else if (m_wacc()) begin
            mq[wr_ch].push_back(data_in);
         end
      end
   end

   function automatic logic [WIDTH-1:0] m_dout();
      if (int'(rd_ch) < NUM_CH && mq[rd_ch].size() > 0) return mq[rd_ch][0];
      return '0;
   endfunction

   function automatic logic [NUM_CH*CNTW-1:0] m_count();
      logic [NUM_CH*CNTW-1:0] r = '0;
      for (int c = 0; c < NUM_CH; c++) r[c*CNTW +: CNTW] = CNTW'(mq[c].size());
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] m_flag(input int kind);
      logic [NUM_CH-1:0] r = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         case (kind)
            0:       r[c] = (mq[c].size() == DEPTH);
            1:       r[c] = (mq[c].size() == 0);
            default: r[c] = (mq[c].size() >= AF);
         endcase
      end
      return r;
   endfunction

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clock) begin
      if (reset_n) begin
         chk("cmp_data_out", 32'(data_out), 32'(m_dout()));
         chk("cmp_count", 32'(count), 32'(m_count()));
         chk("cmp_full", 32'(full), 32'(m_flag(0)));
         chk("cmp_empty", 32'(empty), 32'(m_flag(1)));
         chk("cmp_almost_full", 32'(almost_full), 32'(m_flag(2)));
         chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
         chk("cmp_underflow", 32'(underflow), 32'(m_unf));
      end
   end

   // One clock of stimulus; returns 1 time unit after the edge with inputs idle
   task automatic cyc(input logic w, input logic wc, input logic [7:0] d,
                      input logic r, input logic rc, input logic clr);
      we = w; wr_ch = wc; data_in = d; re = r; rd_ch = rc; clear_err = clr;
      @(posedge clock);
      #1;
      we = 1'b0; wr_ch = '0; data_in = '0; re = 1'b0; rd_ch = '0; clear_err = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_empty", 32'(empty), 32'h3);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_af", 32'(almost_full), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      chk("rst_unf", 32'(underflow), 32'h0);
      chk("rst_dout", 32'(data_out), 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // fill ch0, then overflow
      cyc(1, 0, 8'hA1, 0, 0, 0);
      chk("t1_count1", 32'(count), 32'h1);
      cyc(1, 0, 8'hA2, 0, 0, 0);
      chk("t1_af", 32'(almost_full), 32'h1);
      chk("t1_count2", 32'(count), 32'h2);
      cyc(1, 0, 8'hA3, 0, 0, 0);
      chk("t1_count3", 32'(count), 32'h3);
      chk("t1_full", 32'(full), 32'h1);
      cyc(1, 0, 8'hEE, 0, 0, 0);
      chk("t1_ovf", 32'(overflow), 32'h1);
      chk("t1_count_hold", 32'(count), 32'h3);
      chk("t1_head", 32'(data_out), 32'hA1);
      cyc(0, 0, 8'h00, 0, 0, 1);
      chk("t1_ovf_clr", 32'(overflow), 32'h0);

      // write+read of a full queue, then drain with wrap
      cyc(1, 0, 8'hA4, 1, 0, 0);
      chk("t2_count", 32'(count), 32'h3);
      chk("t2_head", 32'(data_out), 32'hA2);
      chk("t2_ovf", 32'(overflow), 32'h0);
      cyc(0, 0, 8'h00, 1, 0, 0);
      chk("t2_head2", 32'(data_out), 32'hA3);

      // write ch1 while reading ch0
      cyc(1, 1, 8'hB1, 1, 0, 0);
      chk("t3_count", 32'(count), 32'h5);
      chk("t3_head0", 32'(data_out), 32'hA4);
      rd_ch = 1'b1;
      #1;
      chk("t3_head1", 32'(data_out), 32'hB1);
      rd_ch = 1'b0;
      cyc(0, 0, 8'h00, 1, 0, 0);
      chk("t3_empty", 32'(empty), 32'h1);
      cyc(0, 0, 8'h00, 1, 1, 0);
      chk("t3_empty_all", 32'(empty), 32'h3);

      // underflow and sticky clear behaviour
      cyc(0, 0, 8'h00, 1, 1, 0);
      chk("t4_unf", 32'(underflow), 32'h1);
      chk("t4_count", 32'(count), 32'h0);
      cyc(0, 0, 8'h00, 0, 0, 1);
      chk("t4_unf_clr", 32'(underflow), 32'h0);
      cyc(0, 0, 8'h00, 1, 1, 1);
      chk("t4_unf_wins", 32'(underflow), 32'h1);
      cyc(0, 0, 8'h00, 0, 0, 1);

      // write+read on an empty queue: no bypass
      cyc(1, 0, 8'hC1, 1, 0, 0);
      chk("t5_unf", 32'(underflow), 32'h1);
      chk("t5_count", 32'(count), 32'h1);
      chk("t5_dout", 32'(data_out), 32'hC1);

      // asynchronous reset in the middle of a cycle
      cyc(1, 0, 8'hC2, 0, 0, 0);
      chk("t6_pre_count", 32'(count), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_empty", 32'(empty), 32'h3);
      chk("t6_count", 32'(count), 32'h0);
      chk("t6_dout", 32'(data_out), 32'h0);
      chk("t6_unf", 32'(underflow), 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      cyc(0, 0, 8'h00, 1, 0, 0);
      chk("t6_post_unf", 32'(underflow), 32'h1);
      chk("t6_post_count", 32'(count), 32'h0);

      // mixed traffic, checked against the model each cycle
      for (int i = 0; i < 60; i++) begin
         cyc((i % 3) != 0, 1'((i >> 1) & 1), 8'(i * 7 + 3),
             (i % 5) >= 3, 1'(i & 1), (i % 7) == 0);
      end
      repeat (2) @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
